// File: rtl/util_rst_seq.sv
// Multi-stage reset release sequencer: HOLD -> LOCK (filtered) -> RELEASE (ordered, gapped) -> DONE.
// Optional lock watchdog with sticky wdt_timeout enabled by defining UTIL_RST_SEQ_WDT_EN.
module util_rst_seq #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int LOCK_FILT   = 4,
  parameter int STAGE_DELAY = 8,
  parameter int CNT_W       = 16,
  parameter int WDT_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  locked_in,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rstn,
  output logic                  seq_done,
  output logic [1:0]            seq_state
`ifdef UTIL_RST_SEQ_WDT_EN
  ,output logic                 wdt_timeout
`endif
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] FILT_C  = CNT_W'(LOCK_FILT);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(STAGE_DELAY);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > 16 || HOLD_CYCLES < 1 || LOCK_FILT < 1 ||
      STAGE_DELAY < 1 || WDT_CYCLES < 1 || CNT_W < 1 || CNT_W > 31 ||
      (HOLD_CYCLES >> CNT_W) != 0 || (LOCK_FILT >> CNT_W) != 0 ||
      (STAGE_DELAY >> CNT_W) != 0 || (WDT_CYCLES >> CNT_W) != 0) begin : g_bad_param
    $error("util_rst_seq: parameter out of range");
  end

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    LOCK    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        hold_cnt, hold_nxt;
  logic [CNT_W-1:0]        filt_cnt, filt_nxt;
  logic [CNT_W-1:0]        dly_cnt, dly_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [NUM_STAGES-1:0]   stage_nxt;
  logic                    done_nxt;
  logic                    abort;

`ifdef UTIL_RST_SEQ_WDT_EN
  localparam logic [CNT_W-1:0] WDT_C = CNT_W'(WDT_CYCLES);
  logic [CNT_W-1:0]        wdt_cnt, wdt_nxt;
  logic                    wdt_to_nxt;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign seq_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      filt_cnt   <= '0;
      dly_cnt    <= '0;
      idx        <= '0;
      stage_rstn <= '0;
      seq_done   <= 1'b0;
`ifdef UTIL_RST_SEQ_WDT_EN
      wdt_cnt     <= '0;
      wdt_timeout <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      filt_cnt   <= filt_nxt;
      dly_cnt    <= dly_nxt;
      idx        <= idx_nxt;
      stage_rstn <= stage_nxt;
      seq_done   <= done_nxt;
`ifdef UTIL_RST_SEQ_WDT_EN
      wdt_cnt     <= wdt_nxt;
      wdt_timeout <= wdt_to_nxt;
`endif
    end
  end

  // Soft reset outranks lock loss; lock loss only aborts once release has begun.
  assign abort = sw_rst_req || (!locked_in && (state == RELEASE || state == DONE));

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    filt_nxt  = filt_cnt;
    dly_nxt   = dly_cnt;
    idx_nxt   = idx;
    stage_nxt = stage_rstn;
    done_nxt  = seq_done;
`ifdef UTIL_RST_SEQ_WDT_EN
    wdt_nxt    = '0;
    wdt_to_nxt = sw_rst_req ? 1'b0 : wdt_timeout;
`endif

    if (abort) begin
      state_nxt = HOLD;
      hold_nxt  = '0;
      filt_nxt  = '0;
      dly_nxt   = '0;
      idx_nxt   = '0;
      stage_nxt = '0;
      done_nxt  = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          hold_nxt = sat_inc(hold_cnt);
          if (hold_nxt == HOLD_C) begin
            state_nxt = LOCK;
            hold_nxt  = '0;
            filt_nxt  = '0;
          end
        end
        LOCK: begin
          filt_nxt = locked_in ? sat_inc(filt_cnt) : '0;
`ifdef UTIL_RST_SEQ_WDT_EN
          wdt_nxt  = sat_inc(wdt_cnt);
`endif
          if (filt_nxt == FILT_C) begin
            state_nxt = RELEASE;
            filt_nxt  = '0;
            dly_nxt   = '0;
            idx_nxt   = '0;
`ifdef UTIL_RST_SEQ_WDT_EN
            wdt_nxt   = '0;
          end else if (wdt_nxt == WDT_C) begin
            state_nxt  = HOLD;
            filt_nxt   = '0;
            hold_nxt   = '0;
            wdt_nxt    = '0;
            wdt_to_nxt = 1'b1;
`endif
          end
        end
        RELEASE: begin
          dly_nxt = sat_inc(dly_cnt);
          if (dly_nxt == DELAY_C) begin
            stage_nxt[idx] = 1'b1;
            dly_nxt        = '0;
            if (idx == LAST_C) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          stage_nxt = '1;
          done_nxt  = 1'b1;
        end
        default: state_nxt = HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_util_rst_seq.sv
// Directed bench for util_rst_seq with defaults (and WDT_CYCLES=20 for the watchdog build).
module tb_util_rst_seq;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       locked_in = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] stage_rstn;
  logic       seq_done;
  logic [1:0] seq_state;
`ifdef UTIL_RST_SEQ_WDT_EN
  logic       wdt_timeout;
`endif

  int edge_n = 0;
  int n_total = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  util_rst_seq #(
    .NUM_STAGES (4),
    .HOLD_CYCLES(16),
    .LOCK_FILT  (4),
    .STAGE_DELAY(8),
    .CNT_W      (16),
    .WDT_CYCLES (20)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .locked_in (locked_in),
    .sw_rst_req(sw_rst_req),
    .stage_rstn(stage_rstn),
    .seq_done  (seq_done),
    .seq_state (seq_state)
`ifdef UTIL_RST_SEQ_WDT_EN
    ,.wdt_timeout(wdt_timeout)
`endif
  );

  typedef struct {
    int         e;
    logic [3:0] st;
    logic       dn;
    logic [1:0] ss;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk_out(input string name, input logic [3:0] st, input logic dn, input logic [1:0] ss);
    chk({name, ".stage"}, 32'(stage_rstn), 32'(st));
    chk({name, ".done"},  32'(seq_done),   32'(dn));
    chk({name, ".state"}, 32'(seq_state),  32'(ss));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) step();
  endtask

  // Holds rstn low for a few clocks, releases it mid-cycle; edge_n counts from 0 afterwards.
  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("in_reset", 4'h0, 1'b0, 2'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    edge_n = 0;
  endtask

  int a;

  initial begin
    tbl[0]  = '{0,  4'h0, 1'b0, 2'd0};
    tbl[1]  = '{15, 4'h0, 1'b0, 2'd0};
    tbl[2]  = '{16, 4'h0, 1'b0, 2'd1};
    tbl[3]  = '{19, 4'h0, 1'b0, 2'd1};
    tbl[4]  = '{20, 4'h0, 1'b0, 2'd2};
    tbl[5]  = '{27, 4'h0, 1'b0, 2'd2};
    tbl[6]  = '{28, 4'h1, 1'b0, 2'd2};
    tbl[7]  = '{35, 4'h1, 1'b0, 2'd2};
    tbl[8]  = '{36, 4'h3, 1'b0, 2'd2};
    tbl[9]  = '{44, 4'h7, 1'b0, 2'd2};
    tbl[10] = '{51, 4'h7, 1'b0, 2'd2};
    tbl[11] = '{52, 4'hF, 1'b1, 2'd3};
    tbl[12] = '{60, 4'hF, 1'b1, 2'd3};

    // Nominal sequence, locked from reset
    locked_in = 1'b1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      run_to(tbl[i].e);
      chk_out($sformatf("nominal[%0d]", i), tbl[i].st, tbl[i].dn, tbl[i].ss);
    end

    // Lock loss in DONE: abort, then identical offsets from the abort edge
    locked_in = 1'b0;
    step();
    chk_out("lockloss_abort", 4'h0, 1'b0, 2'd0);
    a = edge_n;
    locked_in = 1'b1;
    run_to(a + 15); chk_out("relock_hold",  4'h0, 1'b0, 2'd0);
    run_to(a + 16); chk_out("relock_lock",  4'h0, 1'b0, 2'd1);
    run_to(a + 20); chk_out("relock_rel",   4'h0, 1'b0, 2'd2);
    run_to(a + 28); chk_out("relock_s0",    4'h1, 1'b0, 2'd2);
    run_to(a + 52); chk_out("relock_done",  4'hF, 1'b1, 2'd3);

    // Lock glitch sampled low at edge 19 only: filter restarts, RELEASE at 23
    do_reset();
    run_to(18);
    locked_in = 1'b0;
    step();
    locked_in = 1'b1;
    run_to(22); chk_out("glitch_lock", 4'h0, 1'b0, 2'd1);
    run_to(23); chk_out("glitch_rel",  4'h0, 1'b0, 2'd2);
    run_to(30); chk_out("glitch_s0n",  4'h0, 1'b0, 2'd2);
    run_to(31); chk_out("glitch_s0",   4'h1, 1'b0, 2'd2);

    // Soft reset sampled at T0+12, held for 3 edges
    do_reset();
    run_to(31);
    chk_out("sw_pre", 4'h1, 1'b0, 2'd2);
    sw_rst_req = 1'b1;
    step(); chk_out("sw_abort", 4'h0, 1'b0, 2'd0);
    step(); step();
    chk_out("sw_held", 4'h0, 1'b0, 2'd0);
    sw_rst_req = 1'b0;
    a = edge_n;
    run_to(a + 15); chk_out("sw_hold15", 4'h0, 1'b0, 2'd0);
    run_to(a + 16); chk_out("sw_lock",   4'h0, 1'b0, 2'd1);
    run_to(a + 28); chk_out("sw_s0",     4'h1, 1'b0, 2'd2);
    run_to(a + 36); chk_out("sw_s1",     4'h3, 1'b0, 2'd2);
    // Simultaneous soft reset and lock loss
    sw_rst_req = 1'b1;
    locked_in  = 1'b0;
    step(); chk_out("sw_and_loss", 4'h0, 1'b0, 2'd0);
    sw_rst_req = 1'b0;
    locked_in  = 1'b1;

    // Async reset between edges during RELEASE
    do_reset();
    run_to(37);
    chk_out("async_pre", 4'h3, 1'b0, 2'd2);
    #2;
    rstn = 1'b0;
    #1;
    chk_out("async_now", 4'h0, 1'b0, 2'd0);
    do_reset();
    run_to(20); chk_out("async_rel",  4'h0, 1'b0, 2'd2);
    run_to(28); chk_out("async_s0",   4'h1, 1'b0, 2'd2);
    run_to(52); chk_out("async_done", 4'hF, 1'b1, 2'd3);

    // Never locked
    locked_in = 1'b0;
    do_reset();
`ifdef UTIL_RST_SEQ_WDT_EN
    run_to(35);
    chk_out("wdt_pre", 4'h0, 1'b0, 2'd1);
    chk("wdt_pre_flag", 32'(wdt_timeout), 32'd0);
    run_to(36);
    chk_out("wdt_fire", 4'h0, 1'b0, 2'd0);
    chk("wdt_fire_flag", 32'(wdt_timeout), 32'd1);
    locked_in = 1'b1;
    run_to(52); chk_out("wdt_retry_lock", 4'h0, 1'b0, 2'd1);
    run_to(56); chk_out("wdt_retry_rel",  4'h0, 1'b0, 2'd2);
    chk("wdt_sticky", 32'(wdt_timeout), 32'd1);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("wdt_clear", 32'(wdt_timeout), 32'd0);
    chk_out("wdt_clear_st", 4'h0, 1'b0, 2'd0);
`else
    run_to(16);
    chk_out("nolock_enter", 4'h0, 1'b0, 2'd1);
    run_to(300);
    chk_out("nolock_stay", 4'h0, 1'b0, 2'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
